// File: rtl/toff_pkg.sv
// Shared definitions for the toff_* blocks: serializer FSM state encoding and default word width.
package toff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } toff_state_e;

  localparam int TOFF_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/toff_gate.sv
// Toffoli gate target output: y = c ^ (a & b).
module toff_gate (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = c ^ (a & b);

endmodule

// File: rtl/toff_mux.sv
// Controlled-swap style 2:1 mux: s=0 passes a_in, s=1 passes b_in.
module toff_mux (
  input  logic s,
  input  logic a_in,
  input  logic b_in,
  output logic y
);

  assign y = s ? b_in : a_in;

endmodule

// File: rtl/toff_serializer.sv
// Parallel-to-serial shifter, LSB first, with a one-cycle done pulse after the last bit.
// Define TOFF_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module toff_serializer
  import toff_pkg::*;
#(
  parameter int WIDTH = TOFF_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

`ifdef TOFF_SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  toff_state_e      r_state;
  toff_state_e      w_state_nxt;
  logic [NBITS-1:0] r_sreg;
  logic [NBITS-1:0] w_sreg_nxt;
  logic [NBITS-1:0] w_load_word;
  logic [NBITS-1:0] w_a_in;
  logic [NBITS-1:0] w_b_in;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_shift;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_shift  = (r_state == SHIFT);

`ifdef TOFF_SERIALIZER_PARITY_EN
  // Parity accumulates through a chain of Toffoli gates with a tied-high control.
  logic [WIDTH:0] w_par;
  assign w_par[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_par
    toff_gate u_par (
      .a (1'b1),
      .b (in_data[i]),
      .c (w_par[i]),
      .y (w_par[i+1])
    );
  end
  assign w_load_word = {w_par[WIDTH], in_data};
`else
  assign w_load_word = in_data;
`endif

  assign w_a_in = w_accept ? w_load_word : r_sreg;
  assign w_b_in = r_sreg >> 1;

  for (genvar i = 0; i < NBITS; i++) begin : g_sreg
    toff_mux u_mux (
      .s    (w_shift),
      .a_in (w_a_in[i]),
      .b_in (w_b_in[i]),
      .y    (w_sreg_nxt[i])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Outputs decode the state directly so reset takes effect without a clock edge.
  assign in_ready  = (r_state == IDLE);
  assign ser_valid = w_shift;
  assign done      = (r_state == DONE);
  assign ser_out   = w_shift & r_sreg[0];

endmodule

// File: tb/tb_toff_serializer.sv
// Self-checking bench for toff_serializer: timeline reference model plus directed and random words.
module tb_toff_serializer;

  localparam int W = 8;
`ifdef TOFF_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB  = W + PAR;
  localparam int NB1 = 1 + PAR;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready, ser_out, ser_valid, done;
  logic         v1;
  logic [0:0]   d1;
  logic         rdy1, so1, sv1, dn1;

  int n_cmp = 0;
  int n_bad = 0;

  toff_serializer #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .done      (done)
  );

  toff_serializer #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .in_data   (d1),
    .in_ready  (rdy1),
    .ser_out   (so1),
    .ser_valid (sv1),
    .done      (dn1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since acceptance (0 = idle); bits 1..NB, then done.
  int           m_t;
  logic [W:0]   m_word;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0;
    end else if (m_t == 0) begin
      if (in_valid) begin
        m_t    <= 1;
        m_word <= {^in_data, in_data};
      end
    end else if (m_t == NB + 1) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic q[$];
  always @(negedge clk) begin
    check("in_ready", in_ready, m_t == 0);
    check("ser_valid", ser_valid, (m_t >= 1) && (m_t <= NB));
    check("done", done, m_t == NB + 1);
    if (m_t >= 1 && m_t <= NB) check("ser_out", ser_out, m_word[m_t-1]);
    if (ser_valid) q.push_back(ser_out);
  end

  task automatic send(input logic [W-1:0] d);
    logic was_ready;
    int   guard;
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    do begin
      was_ready = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!was_ready && guard < 50);
    if (!was_ready) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("idle_timeout", in_ready, 1'b1);
  endtask

  function automatic logic [31:0] q_word(input int first);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < W && first + i < q.size(); i++) v[i] = q[first+i];
    return v;
  endfunction

  initial begin
    int lowcnt;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    v1       = 1'b0;
    d1       = 1'b0;
    #1;
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_in_ready1", rdy1, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single-bit instance: data 1 (parity of a single 1 is also 1).
    v1 = 1'b1;
    d1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    for (int k = 0; k < NB1; k++) begin
      check("w1_valid", sv1, 1'b1);
      check("w1_bit", so1, 1'b1);
      check("w1_done_early", dn1, 1'b0);
      @(posedge clk);
      #1;
    end
    check("w1_done", dn1, 1'b1);
    check("w1_valid_off", sv1, 1'b0);
    @(posedge clk);
    #1;
    check("w1_ready", rdy1, 1'b1);

    // Basic word
    q.delete();
    send(8'hA5);
    wait_idle();
    check("a5_nbits", q.size(), NB);
    check("a5_bits", q_word(0), 32'hA5);

    // Parity / length of the last bit
    q.delete();
    send(8'h07);
    wait_idle();
    check("07_nbits", q.size(), NB);
    check("07_last", q[NB-1], PAR == 1);
    q.delete();
    send(8'h03);
    wait_idle();
    check("03_last", q[NB-1], 1'b0);

    // Back-to-back with in_valid held high
    q.delete();
    send(8'hFF);
    in_valid = 1'b1;
    in_data  = 8'h00;
    lowcnt   = 0;
    while (!in_ready && lowcnt < 50) begin
      lowcnt++;
      @(posedge clk);
      #1;
    end
    check("hold_low_cycles", lowcnt, NB + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();
    check("hold_nbits", q.size(), 2 * NB);
    check("hold_word0", q_word(0), 32'hFF);
    check("hold_word1", q_word(NB), 32'h00);

    // Asynchronous reset during the 4th bit
    send(8'hA5);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ser_valid", ser_valid, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_ser_out", ser_out, 1'b0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    send(8'h3C);
    wait_idle();
    check("3c_nbits", q.size(), NB);
    check("3c_bits", q_word(0), 32'h3C);

    // Random traffic; inputs change freely while busy
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      if (c == 200) begin
        #3 rst = 1'b1;
        #1 check("rand_arst_ready", in_ready, 1'b1);
        #2 rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toff_serializer.md
TOFF_SERIALIZER -- requirements
Module: toff_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, number of data bits per word (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  parallel word offered.
REQ-005 SHALL have port: in_data  input  WIDTH  parallel word.
REQ-006 SHALL have port: in_ready  output  1  block can accept a word.
REQ-007 SHALL have port: ser_out  output  1  serial data bit, LSB first.
REQ-008 SHALL have port: ser_valid  output  1  ser_out carries a valid bit.
REQ-009 SHALL have port: done  output  1  single-cycle pulse after the last bit.

Function
REQ-010 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-011 SHALL, in IDLE: drive in_ready=1, ser_valid=0 and done=0.
REQ-012 SHALL, in IDLE on in_valid&in_ready: load in_data into the shift register, clear the bit counter and go to SHIFT.
REQ-013 SHALL, in SHIFT: drive ser_valid=1 and ser_out=sreg[0], shift sreg right with zero fill and increment the counter every cycle.
REQ-014 SHALL leave SHIFT for DONE on the cycle the last bit is presented (counter == NBITS-1, where NBITS = WIDTH, or WIDTH+1 with parity).
REQ-015 SHALL, in DONE: drive done=1, ser_valid=0 and in_ready=0 for exactly one cycle, then return to IDLE.
REQ-016 SHALL have latency: first bit valid the cycle after acceptance; done asserted NBITS+1 cycles after acceptance; one word per NBITS+2 cycles.
REQ-017 SHALL ignore in_valid and in_data outside IDLE (in_ready=0); data is sampled only at acceptance.
REQ-018 SHALL form each sreg bit's next value with a Toffoli mux: select 0 = hold or load, select 1 = shift-in neighbour.
REQ-019 SHALL size the counter at $clog2(WIDTH+2) bits and never let it wrap during a word.
REQ-020 SHALL, when WIDTH=1, present one bit in SHIFT and then go to DONE.

Reset
REQ-021 SHALL, on rst assertion at any time (including mid-SHIFT), immediately force state=IDLE, sreg=0, counter=0, ser_out=0, ser_valid=0 and done=0; the word in flight is discarded.
REQ-022 SHALL drive in_ready=1 while rst is asserted and after its release.

Configuration
REQ-023 SHALL support macro TOFF_SERIALIZER_PARITY_EN.
REQ-024 SHALL, when TOFF_SERIALIZER_PARITY_EN is defined: compute even parity of in_data at acceptance as a chain of Toffoli XORs (c ^ (1 & d)), shift it out as bit WIDTH, and set NBITS=WIDTH+1.
REQ-025 SHALL, when TOFF_SERIALIZER_PARITY_EN is not defined: contain no parity logic and set NBITS=WIDTH.

Structure
REQ-026 SHALL take from shared package toff_pkg: the state typedef (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the constant TOFF_DEFAULT_WIDTH=8.
REQ-027 SHALL instantiate the existing toff_mux once per sreg bit as its only sub-module (S=1 selects b_in); the Toffoli parity XOR uses toff_gate.

Verification
REQ-028 SHALL verify: WIDTH=8, accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles, done=1 on the next cycle, in_ready=1 the cycle after.
REQ-029 SHALL verify: in_valid held high with 8'hFF then 8'h00 -> in_ready low for 9 cycles, second word accepted on the first IDLE cycle, no bit lost or repeated.
REQ-030 SHALL verify: rst asserted during the 4th bit of 8'hA5 -> ser_valid=0, done=0 and in_ready=1 without waiting for a clock edge; next word 8'h3C serialises correctly.
REQ-031 SHALL verify: TOFF_SERIALIZER_PARITY_EN defined, 8'h07 -> 9 valid bits, 9th bit=1; 8'h03 -> 9th bit=0; undefined -> exactly 8 bits.
REQ-032 SHALL verify: WIDTH=1, in_data=1'b1 -> one ser_valid cycle with ser_out=1, done on the following cycle.
